// File: rtl/enc_block_assembler.sv
// Packs a tagged byte stream into 128-bit messages and hands each one to the
// XTEA core as two 64-bit blocks (high half first) over a valid/ready link.
module enc_block_assembler #(
   parameter int TAG_CHECK = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  data_in,
   input  logic        req,
   output logic [63:0] blk_out,
   output logic        blk_valid,
   input  logic        blk_ready,
   output logic        blk_last,
   output logic        tag_err,
   output logic        ovf_err,
   output logic [7:0]  blk_count
);

   typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;

   state_t         state_q, state_d;
   logic [3:0]     byte_cnt_q, byte_cnt_d;
   logic [127:0]   asm_q, asm_d;
   logic [127:0]   buf_q, buf_d;
   logic [63:0]    blk_out_q, blk_out_d;
   logic           blk_valid_q, blk_valid_d;
   logic           blk_last_q, blk_last_d;
   logic           tag_err_q, tag_err_d;
   logic           ovf_err_q, ovf_err_d;
   logic [7:0]     blk_count_q, blk_count_d;

   logic           tag_ok;
   logic           complete;
   logic           lo_handshake;
   logic           transfer;
   logic [6:0]     byte_idx;

   // Byte k lands at bit 127-8k, which is simply {~k, 3'b111}.
   assign byte_idx     = {~byte_cnt_q, 3'b111};
   assign tag_ok       = (TAG_CHECK == 0) || (data_in[9:8] == byte_cnt_q[1:0]);
   assign lo_handshake = (state_q == SEND_LO) && blk_ready;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
      asm_d      = asm_q;
      byte_cnt_d = byte_cnt_q;
      tag_err_d  = tag_err_q;
      complete   = 1'b0;

      if (req) begin
         if (tag_ok) begin
            asm_d[byte_idx -: 8] = data_in[7:0];
            byte_cnt_d           = byte_cnt_q + 4'd1;
            complete             = (byte_cnt_q == 4'd15);
         end else begin
            tag_err_d = 1'b1;
            if (data_in[9:8] == 2'b00) begin
               asm_d[127 -: 8] = data_in[7:0];
               byte_cnt_d      = 4'd1;
            end else begin
               byte_cnt_d = 4'd0;
            end
         end
      end

      // A finished message can only be taken when the buffer is free or freeing this very edge.
      transfer  = complete && ((state_q == IDLE) || lo_handshake);
      ovf_err_d = ovf_err_q || (complete && !transfer);

      state_d     = state_q;
      buf_d       = transfer ? asm_d : buf_q;
      blk_count_d = blk_count_q;
      unique case (state_q)
         IDLE:    if (transfer)  state_d = SEND_HI;
         SEND_HI: if (blk_ready) state_d = SEND_LO;
         SEND_LO: if (blk_ready) begin
            state_d     = transfer ? SEND_HI : IDLE;
            blk_count_d = blk_count_q + 8'd1;
         end
         default: state_d = IDLE;
      endcase

      blk_valid_d = (state_d != IDLE);
      blk_last_d  = (state_d == SEND_LO);
      unique case (state_d)
         SEND_HI: blk_out_d = buf_d[127:64];
         SEND_LO: blk_out_d = buf_d[63:0];
         default: blk_out_d = blk_out_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         byte_cnt_q  <= '0;
         asm_q       <= '0;
         buf_q       <= '0;
         blk_out_q   <= '0;
         blk_valid_q <= 1'b0;
         blk_last_q  <= 1'b0;
         tag_err_q   <= 1'b0;
         ovf_err_q   <= 1'b0;
         blk_count_q <= '0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         asm_q       <= asm_d;
         buf_q       <= buf_d;
         blk_out_q   <= blk_out_d;
         blk_valid_q <= blk_valid_d;
         blk_last_q  <= blk_last_d;
         tag_err_q   <= tag_err_d;
         ovf_err_q   <= ovf_err_d;
         blk_count_q <= blk_count_d;
      end
   end

   assign blk_out   = blk_out_q;
   assign blk_valid = blk_valid_q;
   assign blk_last  = blk_last_q;
   assign tag_err   = tag_err_q;
   assign ovf_err   = ovf_err_q;
   assign blk_count = blk_count_q;

endmodule

// File: tb/tb_enc_block_assembler.sv
// Scoreboard bench: stimulus pushes expected {last, block} pairs, a negedge
// monitor pops and compares them on every valid/ready handshake.
module tb_enc_block_assembler;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  data_in;
   logic        req;
   logic [63:0] blk_out;
   logic        blk_valid;
   logic        blk_ready;
   logic        blk_last;
   logic        tag_err;
   logic        ovf_err;
   logic [7:0]  blk_count;

   int checks = 0;
   int errors = 0;
   logic [64:0] sb[$];

   enc_block_assembler #(.TAG_CHECK(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .req       (req),
      .blk_out   (blk_out),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_last  (blk_last),
      .tag_err   (tag_err),
      .ovf_err   (ovf_err),
      .blk_count (blk_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_msg(input logic [127:0] m);
      sb.push_back({1'b0, m[127:64]});
      sb.push_back({1'b1, m[63:0]});
   endtask

   task automatic send_byte(input logic [1:0] tag, input logic [7:0] b);
      req     = 1'b1;
      data_in = {tag, b};
      @(posedge clk); #1;
      req     = 1'b0;
   endtask

   function automatic logic [7:0] byte_of(input logic [127:0] m, input int k);
      return m[127-8*k -: 8];
   endfunction

   task automatic send_msg(input logic [127:0] m);
      for (int k = 0; k < 16; k++) send_byte(2'(k), byte_of(m, k));
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      req     = 1'b1;
      data_in = 10'h0AB;
      idle(2);
      reset   = 1'b0;
      req     = 1'b0;
      check("rst_valid", blk_valid, 0);
      check("rst_last", blk_last, 0);
      check("rst_out", blk_out, 0);
      check("rst_tag_err", tag_err, 0);
      check("rst_ovf_err", ovf_err, 0);
      check("rst_count", blk_count, 0);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || blk_valid) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, (n < 200), 1);
   endtask

   // Monitor: compares every handshake and the stability of stalled blocks.
   initial begin
      logic        stall_prev = 1'b0;
      logic [64:0] held = '0;
      logic [64:0] exp;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("hold_valid", blk_valid, 1);
               check("hold_block", {blk_last, blk_out}, held);
            end
            if (blk_valid && blk_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_block: got %h expected no block", {blk_last, blk_out});
               end else begin
                  exp = sb.pop_front();
                  check("block", {blk_last, blk_out}, exp);
               end
            end
            stall_prev = blk_valid && !blk_ready;
            held       = {blk_last, blk_out};
         end
      end
   end

   initial begin
      logic [127:0] m1 = 128'hA5A5A5A501234567FEDCBA985A5A5A5A;
      logic [127:0] m2 = 128'h00112233445566778899AABBCCDDEEFF;
      logic [127:0] m3 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
      logic [127:0] m4 = 128'hDEADBEEFCAFEF00D1234ABCD5678EF01;

      reset     = 1'b1;
      req       = 1'b0;
      data_in   = '0;
      blk_ready = 1'b0;
      do_reset();

      // Basic delivery with the core always ready.
      blk_ready = 1'b1;
      push_msg(m1);
      send_msg(m1);
      check("latency_valid", blk_valid, 1);
      check("latency_hi", blk_out, m1[127:64]);
      drain("basic_drain");
      check("basic_count", blk_count, 1);
      check("basic_tag_err", tag_err, 0);
      check("basic_ovf_err", ovf_err, 0);

      // Backpressure: high half held for 5 cycles.
      blk_ready = 1'b0;
      push_msg(m1);
      send_msg(m1);
      idle(5);
      check("bp_hi_held", {blk_valid, blk_last, blk_out}, {2'b10, m1[127:64]});
      check("bp_count_held", blk_count, 1);
      blk_ready = 1'b1;
      drain("bp_drain");
      check("bp_count", blk_count, 2);

      // Tag error: byte 5 arrives tagged 0 and restarts the message.
      for (int k = 0; k < 5; k++) send_byte(2'(k), 8'hEE);
      push_msg(m2);
      send_msg(m2);
      drain("tag_drain");
      check("tag_err_set", tag_err, 1);
      check("tag_count", blk_count, 3);
      // Non-zero mismatched tag is dropped entirely.
      for (int k = 0; k < 3; k++) send_byte(2'(k), 8'h77);
      send_byte(2'd1, 8'h99);
      push_msg(m3);
      send_msg(m3);
      drain("tag2_drain");
      check("tag2_count", blk_count, 4);

      // Overflow: second message completes while the first is stalled.
      do_reset();
      blk_ready = 1'b0;
      push_msg(m1);
      send_msg(m1);
      send_msg(m2);
      check("ovf_err_set", ovf_err, 1);
      check("ovf_count_held", blk_count, 0);
      check("ovf_hi_held", blk_out, m1[127:64]);
      blk_ready = 1'b1;
      drain("ovf_drain");
      check("ovf_count", blk_count, 1);

      // Gaps plus byte 15 landing on the SEND_LO handshake.
      do_reset();
      blk_ready = 1'b0;
      push_msg(m3);
      send_msg(m3);
      push_msg(m4);
      for (int k = 0; k < 16; k++) begin
         if (k > 0 && k < 14) idle($urandom_range(0, 2));
         if (k == 14) blk_ready = 1'b1;
         send_byte(2'(k), byte_of(m4, k));
      end
      check("sim_direct_hi", {blk_valid, blk_last, blk_out}, {2'b10, m4[127:64]});
      check("sim_count_mid", blk_count, 1);
      drain("sim_drain");
      check("sim_count", blk_count, 2);
      check("sim_ovf_err", ovf_err, 0);

      // Reset after byte 9 abandons the partial message.
      for (int k = 0; k < 10; k++) send_byte(2'(k), byte_of(m2, k));
      do_reset();
      idle(3);
      check("abandon_no_valid", blk_valid, 0);
      push_msg(m2);
      send_msg(m2);
      drain("post_rst_drain");
      check("post_rst_count", blk_count, 1);
      check("post_rst_errs", {tag_err, ovf_err}, 0);
      check("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
